// File: rtl/expr_pkg.sv
// rtl/expr_pkg.sv - shared types and ASCII constants for the expression checker
package expr_pkg;

    typedef enum logic [2:0] {
        S_START = 3'd0,
        S_OPND  = 3'd1,
        S_NUM   = 3'd2,
        S_CLOSE = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_STAR  = 8'h2A;
    localparam logic [7:0] CH_SLASH = 8'h2F;
    localparam logic [7:0] CH_LPAR  = 8'h28;
    localparam logic [7:0] CH_RPAR  = 8'h29;
    localparam logic [7:0] CH_TERM  = 8'h3B;

    localparam int OP_ADD = 0;
    localparam int OP_SUB = 1;
    localparam int OP_MUL = 2;
    localparam int OP_DIV = 3;

endpackage

// File: rtl/expr_char_class.sv
// rtl/expr_char_class.sv - combinational ASCII character classifier
module expr_char_class
    import expr_pkg::*;
#(
    parameter int         DATA_W   = 8,
    parameter logic [3:0] OP_MASK  = 4'b0101,
    parameter bit         PAREN_EN = 1'b1
) (
    input  logic [DATA_W-1:0] in,
    output logic              is_digit,
    output logic              is_op,
    output logic              is_lpar,
    output logic              is_rpar,
    output logic              is_term,
    output logic              is_illegal
);

    logic       hi_ok;
    logic [7:0] ch;

    // Any set bit above the ASCII byte makes the character illegal.
    if (DATA_W > 8) begin : g_hi
        assign hi_ok = ~|in[DATA_W-1:8];
    end else begin : g_no_hi
        assign hi_ok = 1'b1;
    end

    assign ch = in[7:0];

    assign is_digit = hi_ok && (ch >= CH_0) && (ch <= CH_9);
    assign is_op    = hi_ok && (((ch == CH_PLUS)  && OP_MASK[OP_ADD]) ||
                                ((ch == CH_MINUS) && OP_MASK[OP_SUB]) ||
                                ((ch == CH_STAR)  && OP_MASK[OP_MUL]) ||
                                ((ch == CH_SLASH) && OP_MASK[OP_DIV]));
    assign is_lpar  = hi_ok && PAREN_EN && (ch == CH_LPAR);
    assign is_rpar  = hi_ok && PAREN_EN && (ch == CH_RPAR);
    assign is_term  = hi_ok && (ch == CH_TERM);

    assign is_illegal = ~(is_digit | is_op | is_lpar | is_rpar | is_term);

endmodule

// File: rtl/expr_checker.sv
// rtl/expr_checker.sv - streaming arithmetic-expression recogniser with registered status
module expr_checker
    import expr_pkg::*;
#(
    parameter int         DATA_W     = 8,
    parameter int         MAX_DIGITS = 4,
    parameter int         MAX_DEPTH  = 3,
    parameter logic [3:0] OP_MASK    = 4'b0101,
    parameter bit         PAREN_EN   = 1'b1,
    parameter int         CNT_W      = 8
) (
    input  logic                           clk,
    input  logic                           clr,
    input  logic                           sync_clr,
    input  logic                           in_valid,
    input  logic [DATA_W-1:0]              in,
    output logic                           out,
    output logic                           err,
    output logic                           done,
    output logic [$clog2(MAX_DEPTH+1)-1:0] depth,
    output logic [CNT_W-1:0]               num_cnt
);

    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);
    localparam int DCNT_W  = $clog2(MAX_DIGITS + 1);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(MAX_DEPTH);
    localparam logic [DCNT_W-1:0]  DIG_MAX   = DCNT_W'(MAX_DIGITS);
    localparam logic [DCNT_W-1:0]  DIG_ONE   = DCNT_W'(1);

    logic is_digit, is_op, is_lpar, is_rpar, is_term, is_illegal;

    state_t             state, state_nxt;
    logic [DEPTH_W-1:0] depth_nxt;
    logic [DCNT_W-1:0]  dcnt, dcnt_nxt;
    logic [CNT_W-1:0]   cnt_nxt, cnt_inc;
    logic               done_nxt, out_nxt, err_nxt;

    expr_char_class #(
        .DATA_W  (DATA_W),
        .OP_MASK (OP_MASK),
        .PAREN_EN(PAREN_EN)
    ) u_class (
        .in        (in),
        .is_digit  (is_digit),
        .is_op     (is_op),
        .is_lpar   (is_lpar),
        .is_rpar   (is_rpar),
        .is_term   (is_term),
        .is_illegal(is_illegal)
    );

    assign cnt_inc = (num_cnt == '1) ? num_cnt : num_cnt + 1'b1;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state   <= S_START;
            depth   <= '0;
            dcnt    <= '0;
            num_cnt <= '0;
            out     <= 1'b0;
            err     <= 1'b0;
            done    <= 1'b0;
        end else if (sync_clr) begin
            state   <= S_START;
            depth   <= '0;
            dcnt    <= '0;
            num_cnt <= '0;
            out     <= 1'b0;
            err     <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            depth   <= depth_nxt;
            dcnt    <= dcnt_nxt;
            num_cnt <= cnt_nxt;
            out     <= out_nxt;
            err     <= err_nxt;
            done    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        depth_nxt = depth;
        dcnt_nxt  = dcnt;
        cnt_nxt   = num_cnt;
        done_nxt  = 1'b0;
        if (in_valid) begin
            case (state)
                S_START, S_OPND: begin
                    // A new expression forgets the previous operand count.
                    if (state == S_START) cnt_nxt = '0;
                    if (is_illegal) begin
                        state_nxt = S_ERR;
                    end else if (is_digit) begin
                        state_nxt = S_NUM;
                        dcnt_nxt  = DIG_ONE;
                    end else if (is_lpar && (depth < DEPTH_MAX)) begin
                        depth_nxt = depth + 1'b1;
                    end else begin
                        state_nxt = S_ERR;
                    end
                end
                S_NUM: begin
                    if (is_illegal) begin
                        state_nxt = S_ERR;
                    end else if (is_digit) begin
                        if (dcnt < DIG_MAX) dcnt_nxt = dcnt + 1'b1;
                        else                state_nxt = S_ERR;
                    end else if (is_op) begin
                        state_nxt = S_OPND;
                        cnt_nxt   = cnt_inc;
                    end else if (is_rpar && (depth != '0)) begin
                        state_nxt = S_CLOSE;
                        depth_nxt = depth - 1'b1;
                        cnt_nxt   = cnt_inc;
                    end else if (is_term && (depth == '0)) begin
                        state_nxt = S_START;
                        cnt_nxt   = cnt_inc;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = S_ERR;
                    end
                end
                S_CLOSE: begin
                    if (is_op) begin
                        state_nxt = S_OPND;
                    end else if (is_rpar && (depth != '0)) begin
                        depth_nxt = depth - 1'b1;
                    end else if (is_term && (depth == '0)) begin
                        state_nxt = S_START;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = S_ERR;
                    end
                end
                S_ERR: begin
                    // Only ';' resynchronises; it never reports completion.
                    if (is_term) begin
                        state_nxt = S_START;
                        depth_nxt = '0;
                        cnt_nxt   = '0;
                    end
                end
                default: state_nxt = S_ERR;
            endcase
        end
    end

    always_comb begin
        out_nxt = ((state_nxt == S_NUM) || (state_nxt == S_CLOSE)) && (depth_nxt == '0);
        err_nxt = (state_nxt == S_ERR);
    end

endmodule

// File: tb/tb_expr_checker.sv
// tb/tb_expr_checker.sv - randomized model-checked bench for expr_checker
module tb_expr_checker;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       sync_clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] ch_in = 8'h00;
    logic       out, err, done;
    logic [1:0] depth;
    logic [7:0] num_cnt;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Grammar-level reference: expecting-operand flag, digit run, nesting and count.
    int m_depth, m_cnt, m_digits;
    bit m_err, m_need, m_fresh, m_done;

    expr_checker #(
        .DATA_W(8), .MAX_DIGITS(4), .MAX_DEPTH(3),
        .OP_MASK(4'b0101), .PAREN_EN(1'b1), .CNT_W(8)
    ) dut (
        .clk(clk), .clr(clr), .sync_clr(sync_clr), .in_valid(in_valid), .in(ch_in),
        .out(out), .err(err), .done(done), .depth(depth), .num_cnt(num_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_depth = 0; m_cnt = 0; m_digits = 0;
        m_err = 0; m_need = 1; m_fresh = 1; m_done = 0;
    endtask

    task automatic m_bump();
        if (m_cnt < 255) m_cnt++;
    endtask

    task automatic m_step(input byte c);
        bit dig, op, lp, rp, tm;
        dig = (c >= "0") && (c <= "9");
        op  = (c == "+") || (c == "*");
        lp  = (c == "(");
        rp  = (c == ")");
        tm  = (c == ";");
        if (m_err) begin
            if (tm) m_reset();
            return;
        end
        if (m_fresh) m_cnt = 0;
        if (m_need) begin
            if (dig) begin m_digits = 1; m_need = 0; m_fresh = 0; end
            else if (lp && m_depth < 3) m_depth++;
            else m_err = 1;
        end else if (m_digits > 0) begin
            if (dig) begin
                if (m_digits < 4) m_digits++; else m_err = 1;
            end else if (op) begin
                m_bump(); m_digits = 0; m_need = 1;
            end else if (rp && m_depth > 0) begin
                m_depth--; m_bump(); m_digits = 0;
            end else if (tm && m_depth == 0) begin
                m_bump(); m_digits = 0; m_need = 1; m_fresh = 1; m_done = 1;
            end else m_err = 1;
        end else begin
            if (op) m_need = 1;
            else if (rp && m_depth > 0) m_depth--;
            else if (tm && m_depth == 0) begin
                m_need = 1; m_fresh = 1; m_done = 1;
            end else m_err = 1;
        end
    endtask

    always @(posedge clk or negedge clr) begin
        if (!clr) m_reset();
        else begin
            m_done = 0;
            if (sync_clr) m_reset();
            else if (in_valid) m_step(ch_in);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_out",   out,     (!m_err && !m_need && m_depth == 0));
            chk("cyc_err",   err,     m_err);
            chk("cyc_done",  done,    m_done);
            chk("cyc_depth", depth,   m_depth);
            chk("cyc_cnt",   num_cnt, m_cnt);
        end
    end

    task automatic send(input byte c);
        ch_in = c;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic send_out(input string s, input string e);
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
            chk($sformatf("out_after_%0d_of_%s", i, s), out, (e[i] == "1"));
        end
    endtask

    initial begin
        int depth_exp[12] = '{1, 1, 1, 2, 2, 2, 2, 1, 0, 0, 0, 0};
        string s;
        byte c;
        int k;

        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", out, 0);
        chk("rst_err", err, 0);
        chk("rst_depth", depth, 0);
        chk("rst_cnt", num_cnt, 0);
        cmp_en = 1'b1;
        clr = 1'b1;
        idle(2);

        send_out("12+3;", "11010");
        chk("t1_done", done, 1);
        chk("t1_cnt", num_cnt, 2);
        chk("t1_err", err, 0);
        idle(1);
        chk("t1_done_pulse", done, 0);
        chk("t1_cnt_kept", num_cnt, 2);

        s = "(4*(5+6))*7;";
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
            chk($sformatf("t2_depth_%0d", i), depth, depth_exp[i]);
        end
        chk("t2_done", done, 1);
        chk("t2_cnt", num_cnt, 4);
        idle(1);
        send_out("(4*(5+6))*7;", "000000001010");

        s = "12345";
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
            chk($sformatf("t3_err_%0d", i), err, (i == 4));
        end
        send("1"); chk("t3_err_1", err, 1);
        send("+"); chk("t3_err_plus", err, 1);
        send(";");
        chk("t3_err_cleared", err, 0);
        chk("t3_depth", depth, 0);
        chk("t3_done", done, 0);
        chk("t3_cnt", num_cnt, 0);

        send("2"); chk("t4_err_2", err, 0);
        send("-"); chk("t4_err_minus", err, 1);
        send_str("1;");
        chk("t4_recover", err, 0);
        s = "((((";
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
            chk($sformatf("t4_paren_err_%0d", i), err, (i == 3));
        end
        chk("t4_depth_capped", depth, 3);
        send_str("1;");

        send_str("9+");
        idle(5);
        chk("t5_hold_out", out, 0);
        chk("t5_hold_cnt", num_cnt, 1);
        sync_clr = 1'b1; in_valid = 1'b1; ch_in = "3";
        @(posedge clk); #1;
        sync_clr = 1'b0; in_valid = 1'b0;
        chk("t5_sclr_out", out, 0);
        chk("t5_sclr_cnt", num_cnt, 0);
        send("+");
        chk("t5_3_not_taken", err, 1);
        send(";");

        send_str("(1+(2");
        in_valid = 1'b0;
        chk("t6_pre_depth", depth, 2);
        chk("t6_pre_cnt", num_cnt, 1);
        #2;
        clr = 1'b0;
        #1;
        chk("t6_async_depth", depth, 0);
        chk("t6_async_cnt", num_cnt, 0);
        chk("t6_async_out", out, 0);
        chk("t6_async_err", err, 0);
        chk("t6_async_done", done, 0);
        @(negedge clk); #1;
        clr = 1'b1;
        send_str("8;");
        chk("t6_done", done, 1);
        chk("t6_cnt", num_cnt, 1);
        idle(1);

        for (int i = 0; i < 3000; i++) begin
            k = $urandom_range(0, 19);
            if (k < 8)       c = byte'(8'h30 + $urandom_range(0, 9));
            else if (k < 10) c = "+";
            else if (k == 10) c = "*";
            else if (k == 11) c = "-";
            else if (k == 12) c = "/";
            else if (k < 15) c = "(";
            else if (k < 17) c = ")";
            else if (k < 19) c = ";";
            else             c = byte'($urandom_range(0, 255));
            ch_in = c;
            in_valid = ($urandom_range(0, 9) != 0);
            sync_clr = ($urandom_range(0, 63) == 0);
            @(posedge clk); #1;
        end
        sync_clr = 1'b0;
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
